seg_letter_decoder: RTL

Inverse of the letter-to-segment renderer: holds a user-edited 17-segment mask and, on request, sequentially matches it against the 12-letter glyph table to recover the 5-bit letter code. Sits between the debounced button pulses and the game/VGA logic. The `mask` output drives the segment colour muxes for live preview. `letter` and `match` feed scoring.

---
 rtl/seg_letter_decoder_if.sv | 26 ++
 rtl/seg_letter_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg_letter_decoder_if.sv
// Button/submit inputs and decoded-letter outputs of seg_letter_decoder.
// master drives the buttons (button logic or bench); slave is the decoder itself.
interface seg_letter_decoder_if;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_toggle;
  logic        btn_clear;
  logic        submit;
  logic [16:0] mask;
  logic [4:0]  cursor;
  logic        cursor_blink;
  logic        busy;
  logic        done;
  logic        match;
  logic [4:0]  letter;

  modport master (
    output btn_next, btn_prev, btn_toggle, btn_clear, submit,
    input  mask, cursor, cursor_blink, busy, done, match, letter
  );

  modport slave (
    input  btn_next, btn_prev, btn_toggle, btn_clear, submit,
    output mask, cursor, cursor_blink, busy, done, match, letter
  );
endinterface

// File: rtl/seg_letter_decoder.sv
// Editable 17-segment mask with a sequential glyph-table scan that recovers the letter code.
// Define SEGDEC_BLINK_EN to build the free-running cursor-blink counter; otherwise cursor_blink is 1.
//
//   state  | meaning
//   S_IDLE | mask editable, waiting for submit
//   S_SCAN | comparing snapshot against glyph entry idx, one entry per cycle
//   S_DONE | result registered, done pulse high
module seg_letter_decoder #(
  parameter int BLINK_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  seg_letter_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t      state;
  logic [16:0] mask_q;
  logic [16:0] snap_q;
  logic [4:0]  cursor_q;
  logic [3:0]  idx_q;
  logic        busy_q;
  logic        done_q;
  logic        match_q;
  logic [4:0]  letter_q;
  logic        blink_q;

  function automatic logic [16:0] glyph_mask(input logic [3:0] i);
    case (i)
      4'd0:    glyph_mask = 17'h143E7;
      4'd1:    glyph_mask = 17'h003FF;
      4'd2:    glyph_mask = 17'h00139;
      4'd3:    glyph_mask = 17'h101F9;
      4'd4:    glyph_mask = 17'h10309;
      4'd5:    glyph_mask = 17'h12830;
      4'd6:    glyph_mask = 17'h00138;
      4'd7:    glyph_mask = 17'h10F36;
      4'd8:    glyph_mask = 17'h0033F;
      4'd9:    glyph_mask = 17'h123E3;
      4'd10:   glyph_mask = 17'h103ED;
      4'd11:   glyph_mask = 17'h10301;
      default: glyph_mask = 17'h00000;
    endcase
  endfunction

  function automatic logic [4:0] glyph_code(input logic [3:0] i);
    case (i)
      4'd0:    glyph_code = 5'd0;
      4'd1:    glyph_code = 5'd1;
      4'd2:    glyph_code = 5'd2;
      4'd3:    glyph_code = 5'd4;
      4'd4:    glyph_code = 5'd8;
      4'd5:    glyph_code = 5'd10;
      4'd6:    glyph_code = 5'd11;
      4'd7:    glyph_code = 5'd12;
      4'd8:    glyph_code = 5'd14;
      4'd9:    glyph_code = 5'd17;
      4'd10:   glyph_code = 5'd18;
      4'd11:   glyph_code = 5'd19;
      default: glyph_code = 5'd31;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mask_q   <= '0;
      snap_q   <= '0;
      cursor_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      letter_q <= 5'd31;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.submit) begin
            snap_q <= mask_q;
            idx_q  <= '0;
            busy_q <= 1'b1;
            state  <= S_SCAN;
          end
          // one edit per cycle: clear > toggle > next > prev
          if (bus.btn_clear) begin
            mask_q <= '0;
          end else if (bus.btn_toggle) begin
            mask_q <= mask_q ^ (17'd1 << cursor_q);
          end else if (bus.btn_next) begin
            cursor_q <= (cursor_q == 5'd16) ? 5'd0 : cursor_q + 5'd1;
          end else if (bus.btn_prev) begin
            cursor_q <= (cursor_q == 5'd0) ? 5'd16 : cursor_q - 5'd1;
          end
        end
        S_SCAN: begin
          if (snap_q == glyph_mask(idx_q)) begin
            letter_q <= glyph_code(idx_q);
            match_q  <= 1'b1;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else if (idx_q == 4'd11) begin
            letter_q <= 5'd31;
            match_q  <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEGDEC_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt + 1'b1;
  end

  assign blink_q = blink_cnt[BLINK_BITS-1];
`else
  // no counter: highlight is always on; parameter stays valid for either build
  assign blink_q = (BLINK_BITS >= 1);
`endif

  assign bus.mask         = mask_q;
  assign bus.cursor       = cursor_q;
  assign bus.cursor_blink = blink_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.match        = match_q;
  assign bus.letter       = letter_q;

endmodule
